// File: rtl/full_sub.sv
// ============================================================================
// full_sub : registered ripple-borrow subtractor, {bo,d} = a - b - c
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_sub #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  logic [WIDTH:0]   w_br;
  logic [WIDTH-1:0] w_d;

  assign w_br[0] = c;

  // One identical full-subtractor cell per bit; borrow ripples upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_d[i]    = a[i] ^ b[i] ^ w_br[i];
    assign w_br[i+1] = (~a[i] & b[i]) | (~a[i] & w_br[i]) | (b[i] & w_br[i]);
  end

  if (LATENCY == 0) begin : g_comb
    logic w_unused_clkrst;
    assign w_unused_clkrst = clk | rst;
    assign d  = w_d;
    assign bo = w_br[WIDTH];
  end else begin : g_pipe
    logic [WIDTH:0] r_stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < LATENCY; s++) begin
          r_stage[s] <= '0;
        end
      end else begin
        r_stage[0] <= {w_br[WIDTH], w_d};
        for (int s = 1; s < LATENCY; s++) begin
          r_stage[s] <= r_stage[s-1];
        end
      end
    end

    assign {bo, d} = r_stage[LATENCY-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_full_sub.sv
// ============================================================================
// tb_full_sub : directed and random checks of full_sub across configurations
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_full_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk0 = 1'b0;
  logic rst0 = 1'b0;

  always #5 clk = ~clk;

  // W1 L1
  logic a1, b1, c1, d1, bo1;
  // W8 L1
  logic [7:0] a8, b8, d8;
  logic c8, bo8;
  // W4 L3
  logic [3:0] a4, b4, d4;
  logic c4, bo4;
  // W1 L0
  logic a0, b0, c0, d0, bo0;
  // W16 L2
  logic [15:0] a16, b16, d16;
  logic c16, bo16;

  full_sub #(.WIDTH(1), .LATENCY(1)) u_w1l1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .bo(bo1));
  full_sub #(.WIDTH(8), .LATENCY(1)) u_w8l1 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .bo(bo8));
  full_sub #(.WIDTH(4), .LATENCY(3)) u_w4l3 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .d(d4), .bo(bo4));
  full_sub #(.WIDTH(1), .LATENCY(0)) u_w1l0 (
    .clk(clk0), .rst(rst0), .a(a0), .b(b0), .c(c0), .d(d0), .bo(bo0));
  full_sub #(.WIDTH(16), .LATENCY(2)) u_w16l2 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .c(c16), .d(d16), .bo(bo16));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Truth table {bo,d} indexed by {a,b,c}
  logic [1:0] tt_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

  logic [7:0] v8a [4] = '{8'h05, 8'h00, 8'h80, 8'hFF};
  logic [7:0] v8b [4] = '{8'h03, 8'h01, 8'h7F, 8'hFF};
  logic       v8c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [8:0] v8e [4] = '{9'h002, 9'h1FF, 9'h000, 9'h1FF};

  logic [3:0] v4a [6] = '{4'h5, 4'h3, 4'hF, 4'h0, 4'h8, 4'hA};
  logic [3:0] v4b [6] = '{4'h3, 4'h5, 4'h0, 4'h0, 4'h8, 4'h3};
  logic       v4c [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [4:0] v4e [6] = '{5'h02, 5'h1E, 5'h0E, 5'h1F, 5'h00, 5'h06};

  logic [16:0] hist [2];

  initial begin
    logic [2:0] idx;
    a1 = 0; b1 = 0; c1 = 0;
    a8 = 0; b8 = 0; c8 = 0;
    a4 = 0; b4 = 0; c4 = 0;
    a0 = 0; b0 = 0; c0 = 0;
    a16 = 0; b16 = 0; c16 = 0;

    #2;
    chk("rst_w1", {30'd0, bo1, d1}, 32'd0);
    chk("rst_w8", {23'd0, bo8, d8}, 32'd0);
    chk("rst_w4", {27'd0, bo4, d4}, 32'd0);
    chk("rst_w16", {15'd0, bo16, d16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1-bit exhaustive truth table, one-edge latency
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      @(negedge clk);
      {a1, b1, c1} = idx;
      @(posedge clk);
      #1;
      chk($sformatf("tt_%0d", i), {30'd0, bo1, d1}, {30'd0, tt_exp[i]});
    end

    // Asynchronous reset with a=0,b=1,c=0 held
    @(negedge clk);
    {a1, b1, c1} = 3'b010;
    @(posedge clk);
    #1;
    chk("w1_pre_rst", {30'd0, bo1, d1}, 32'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("w1_async_rst", {30'd0, bo1, d1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("w1_rst_release", {30'd0, bo1, d1}, 32'd3);

    // 8-bit directed vectors
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a8 = v8a[i]; b8 = v8b[i]; c8 = v8c[i];
      @(posedge clk);
      #1;
      chk($sformatf("w8_%0d", i), {23'd0, bo8, d8}, {23'd0, v8e[i]});
    end

    // 4-bit, three-stage stream: result i appears after edge i+2
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 6) begin
        a4 = v4a[i]; b4 = v4b[i]; c4 = v4c[i];
      end else begin
        a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 2) chk($sformatf("w4_stream_%0d", i - 2), {27'd0, bo4, d4}, {27'd0, v4e[i-2]});
    end

    // Mid-stream reset discards all in-flight results
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a4 = v4a[i+1]; b4 = v4b[i+1]; c4 = v4c[i+1];
      @(posedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("w4_mid_rst", {27'd0, bo4, d4}, 32'd0);
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h2; c4 = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w4_after_rst_%0d", i), {27'd0, bo4, d4}, (i == 2) ? 32'h05 : 32'h00);
    end

    // Combinational configuration
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {a0, b0, c0} = idx;
      #0;
      #1;
      chk($sformatf("l0_%0d", i), {30'd0, bo0, d0}, {30'd0, tt_exp[i]});
    end
    {a0, b0, c0} = 3'b011;
    #1;
    rst0 = 1'b1; #1;
    chk("l0_rst_hi", {30'd0, bo0, d0}, 32'd2);
    clk0 = 1'b1; #1; clk0 = 1'b0; #1;
    chk("l0_clk_tog", {30'd0, bo0, d0}, 32'd2);
    rst0 = 1'b0; #1;
    chk("l0_rst_lo", {30'd0, bo0, d0}, 32'd2);

    // 16-bit random against a 17-bit reference delayed two edges
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      hist[i % 2] = {1'b0, a16} - {1'b0, b16} - {16'd0, c16};
      @(posedge clk);
      #1;
      if (i >= 1) chk("w16_rand", {15'd0, bo16, d16}, {15'd0, hist[(i - 1) % 2]});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
